// File: rtl/alu_pkg.sv
// Shared opcode map, flag layout, sequencer states and opcode classification helpers
// for the ALU issue/writeback sequencer.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_SUB   = 5'h02;
  localparam logic [4:0] OP_MUL   = 5'h03;
  localparam logic [4:0] OP_AND   = 5'h04;
  localparam logic [4:0] OP_OR    = 5'h05;
  localparam logic [4:0] OP_XOR   = 5'h06;
  localparam logic [4:0] OP_NOT   = 5'h07;
  localparam logic [4:0] OP_DIV   = 5'h08;
  localparam logic [4:0] OP_MOD   = 5'h09;
  localparam logic [4:0] OP_SHL   = 5'h0A;
  localparam logic [4:0] OP_SHR   = 5'h0B;
  localparam logic [4:0] OP_SAR   = 5'h0C;
  localparam logic [4:0] OP_ROL   = 5'h0D;
  localparam logic [4:0] OP_ROR   = 5'h0E;
  localparam logic [4:0] OP_NEG   = 5'h0F;
  localparam logic [4:0] OP_MOV   = 5'h10;
  localparam logic [4:0] OP_MOVI  = 5'h11;
  localparam logic [4:0] OP_CMP   = 5'h12;
  localparam logic [4:0] OP_POW   = 5'h13;
  localparam logic [4:0] OP_LOG2  = 5'h14;
  localparam logic [4:0] OP_LOG10 = 5'h15;
  localparam logic [4:0] OP_SQRT  = 5'h16;
  localparam logic [4:0] OP_EXP   = 5'h17;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_FIRE,
    ST_SAMPLE,
    ST_WB
  } state_t;

  function automatic logic op_is_legal(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_EXP);
  endfunction

  function automatic logic op_writes_rd(input logic [4:0] op);
    return op_is_legal(op) && (op != OP_CMP);
  endfunction

  function automatic logic op_updates_flags(input logic [4:0] op);
    return ((op >= OP_ADD) && (op <= OP_NEG)) || (op == OP_CMP);
  endfunction

  function automatic logic op_is_divmod(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// General register file: two combinational operand reads, one debug read,
// one synchronous write port, cleared on reset.
module alu_regfile #(
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [15:0]       rd_data_a,
  output logic [15:0]       rd_data_b,
  output logic [15:0]       dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [15:0]       wr_data
);

  logic [15:0] regs_reg [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs_reg[rd_addr_a];
  assign rd_data_b = regs_reg[rd_addr_b];
  assign dbg_data  = regs_reg[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue and writeback sequencer in front of a toggle-enabled ALU: accepts one
// instruction, presents operands, toggles enable, samples, writes back.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int NREGS         = 8,
  parameter int REG_AW        = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              instr_use_imm,
  input  logic [15:0]       instr_imm,
  output logic              alu_enable,
  output logic [4:0]        alu_operation,
  output logic [15:0]       alu_in1,
  output logic [15:0]       alu_in2,
  input  logic [15:0]       alu_data_out,
  input  logic [3:0]        alu_flags,
  output logic              done,
  output logic [15:0]       result,
  output logic [3:0]        flags_q,
  output logic              div_zero_err,
  output logic              illegal_op_err,
  input  logic              err_clr,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [15:0]       dbg_data
);

  state_t            state_reg;
  logic [3:0]        settle_cnt_reg;
  logic [REG_AW-1:0] rd_reg;
  logic              alu_enable_reg;
  logic [4:0]        alu_operation_reg;
  logic [15:0]       alu_in1_reg;
  logic [15:0]       alu_in2_reg;
  logic              done_reg;
  logic [15:0]       result_reg;
  logic [3:0]        flags_cap_reg;
  logic [3:0]        flags_q_reg;
  logic              div_zero_err_reg;
  logic              illegal_op_err_reg;

  logic [15:0] rf_data_a;
  logic [15:0] rf_data_b;
  logic        rf_we;
  logic        div_zero;
  logic        skip_sample;

  // The ALU leaves stale output on a zero divisor, so that case never trusts it.
  assign div_zero    = op_is_divmod(alu_operation_reg) && (alu_in2_reg == '0);
  assign skip_sample = !op_is_legal(alu_operation_reg) || div_zero;
  assign rf_we       = (state_reg == ST_WB) && op_writes_rd(alu_operation_reg) && !div_zero;

  alu_regfile #(
    .NREGS (NREGS),
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr_a(instr_rs1),
    .rd_addr_b(instr_rs2),
    .dbg_addr (dbg_addr),
    .rd_data_a(rf_data_a),
    .rd_data_b(rf_data_b),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wr_addr  (rd_reg),
    .wr_data  (result_reg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      settle_cnt_reg     <= '0;
      rd_reg             <= '0;
      alu_enable_reg     <= 1'b0;
      alu_operation_reg  <= '0;
      alu_in1_reg        <= '0;
      alu_in2_reg        <= '0;
      done_reg           <= 1'b0;
      result_reg         <= '0;
      flags_cap_reg      <= '0;
      flags_q_reg        <= '0;
      div_zero_err_reg   <= 1'b0;
      illegal_op_err_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      // A clear is overridden by an error raised in the same cycle below.
      if (err_clr) begin
        div_zero_err_reg   <= 1'b0;
        illegal_op_err_reg <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            // Sources are read here, before any writeback of this instruction.
            alu_operation_reg <= instr_op;
            rd_reg            <= instr_rd;
            alu_in1_reg       <= rf_data_a;
            alu_in2_reg       <= instr_use_imm ? instr_imm : rf_data_b;
            state_reg         <= ST_READ;
          end
        end
        ST_READ: begin
          state_reg <= ST_FIRE;
        end
        ST_FIRE: begin
          if (op_is_legal(alu_operation_reg)) begin
            alu_enable_reg <= ~alu_enable_reg;
          end
          settle_cnt_reg <= 4'(SETTLE_CYCLES - 1);
          state_reg      <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (settle_cnt_reg == '0) begin
            if (!skip_sample) begin
              result_reg    <= alu_data_out;
              flags_cap_reg <= alu_flags;
            end
            done_reg  <= 1'b1;
            state_reg <= ST_WB;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - 4'd1;
          end
        end
        ST_WB: begin
          if (!op_is_legal(alu_operation_reg)) begin
            illegal_op_err_reg <= 1'b1;
          end else if (div_zero) begin
            div_zero_err_reg <= 1'b1;
          end else if (op_updates_flags(alu_operation_reg)) begin
            flags_q_reg <= flags_cap_reg;
          end
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready    = (state_reg == ST_IDLE);
  assign alu_enable     = alu_enable_reg;
  assign alu_operation  = alu_operation_reg;
  assign alu_in1        = alu_in1_reg;
  assign alu_in2        = alu_in2_reg;
  assign done           = done_reg;
  assign result         = result_reg;
  assign flags_q        = flags_q_reg;
  assign div_zero_err   = div_zero_err_reg;
  assign illegal_op_err = illegal_op_err_reg;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural toggle-driven ALU, directed vector table,
// hand-written corner sequences and randomized instructions against a model.
module tb_alu_issue_seq;
  import alu_pkg::*;

  localparam int NREGS  = 8;
  localparam int REG_AW = 3;
  localparam int SETTLE = 1;
  localparam int LAT    = 3 + SETTLE;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        use_imm;
    logic [15:0] imm;
  } ins_t;

  typedef struct {
    ins_t        in;
    logic [2:0]  chk_reg;
    logic [15:0] chk_val;
    logic [3:0]  chk_flags;
    logic        chk_div;
    logic        chk_ill;
    logic        clr_after;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [4:0]        instr_op = '0;
  logic [REG_AW-1:0] instr_rd = '0;
  logic [REG_AW-1:0] instr_rs1 = '0;
  logic [REG_AW-1:0] instr_rs2 = '0;
  logic              instr_use_imm = 1'b0;
  logic [15:0]       instr_imm = '0;
  logic              alu_enable;
  logic [4:0]        alu_operation;
  logic [15:0]       alu_in1;
  logic [15:0]       alu_in2;
  logic [15:0]       alu_data_out = '0;
  logic [3:0]        alu_flags = '0;
  logic              done;
  logic [15:0]       result;
  logic [3:0]        flags_q;
  logic              div_zero_err;
  logic              illegal_op_err;
  logic              err_clr = 1'b0;
  logic [REG_AW-1:0] dbg_addr = '0;
  logic [15:0]       dbg_data;

  int checks = 0;
  int failures = 0;
  int tog_cnt = 0;
  int done_cnt = 0;

  logic [15:0] m_regs [NREGS];
  logic [3:0]  m_flags;
  logic [15:0] m_result;
  logic        m_div;
  logic        m_ill;
  logic [19:0] alu_fr;

  always #25 clk = ~clk;

  alu_issue_seq #(
    .NREGS        (NREGS),
    .REG_AW       (REG_AW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rd      (instr_rd),
    .instr_rs1     (instr_rs1),
    .instr_rs2     (instr_rs2),
    .instr_use_imm (instr_use_imm),
    .instr_imm     (instr_imm),
    .alu_enable    (alu_enable),
    .alu_operation (alu_operation),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_data_out  (alu_data_out),
    .alu_flags     (alu_flags),
    .done          (done),
    .result        (result),
    .flags_q       (flags_q),
    .div_zero_err  (div_zero_err),
    .illegal_op_err(illegal_op_err),
    .err_clr       (err_clr),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  // Returns {Z,N,C,V, result[15:0]} for the behavioural ALU.
  function automatic logic [19:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    logic        v;
    w = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_DIV:  r = a / b;
      OP_MOD:  r = a % b;
      OP_SHL:  r = a << b[3:0];
      OP_SHR:  r = a >> b[3:0];
      OP_NEG:  r = 16'd0 - a;
      OP_MOV:  r = a;
      OP_MOVI: r = b;
      default: r = (a ^ b) + 16'(op);
    endcase
    return {r == 16'd0, r[15], c, v, r};
  endfunction

  // The ALU evaluates on either enable edge; it holds stale output for a zero divisor.
  always @(alu_enable) begin
    tog_cnt++;
    if (alu_operation >= 5'h01 && alu_operation <= 5'h17 &&
        !((alu_operation == 5'h08 || alu_operation == 5'h09) && alu_in2 == 16'd0)) begin
      alu_fr       = alu_fn(alu_operation, alu_in1, alu_in2);
      alu_data_out = alu_fr[15:0];
      alu_flags    = alu_fr[19:16];
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm);
    ins_t t;
    t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.use_imm = use_imm; t.imm = imm;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_flags = '0; m_result = '0; m_div = 1'b0; m_ill = 1'b0;
  endtask

  // Architectural effect of one retired instruction, straight from the writeback rules.
  task automatic model_apply(input ins_t in, input logic clr, output int exp_tog);
    logic [15:0] b;
    logic [19:0] fr;
    if (clr) begin
      m_div = 1'b0;
      m_ill = 1'b0;
    end
    b = in.use_imm ? in.imm : m_regs[in.rs2];
    exp_tog = 0;
    if (in.op == 5'h00 || in.op >= 5'h18) begin
      m_ill = 1'b1;
    end else begin
      exp_tog = 1;
      if ((in.op == 5'h08 || in.op == 5'h09) && b == 16'd0) begin
        m_div = 1'b1;
      end else begin
        fr = alu_fn(in.op, m_regs[in.rs1], b);
        m_result = fr[15:0];
        if (in.op != 5'h12) m_regs[in.rd] = fr[15:0];
        if (in.op <= 5'h0F || in.op == 5'h12) m_flags = fr[19:16];
      end
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = REG_AW'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), dbg_data, m_regs[i]);
    end
    chk({tag, " flags_q"}, flags_q, m_flags);
    chk({tag, " result"}, result, m_result);
    chk({tag, " div_zero_err"}, div_zero_err, m_div);
    chk({tag, " illegal_op_err"}, illegal_op_err, m_ill);
  endtask

  task automatic drive(input ins_t in);
    instr_op = in.op; instr_rd = in.rd; instr_rs1 = in.rs1; instr_rs2 = in.rs2;
    instr_use_imm = in.use_imm; instr_imm = in.imm;
  endtask

  // Returns at the negedge before the accepting posedge.
  task automatic accept(input ins_t in, input string tag);
    bit got;
    got = 1'b0;
    @(negedge clk);
    drive(in);
    instr_valid = 1'b1;
    for (int c = 0; c < 30 && !got; c++) begin
      if (instr_ready === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, " accept"}, 32'(got), 32'd1);
  endtask

  task automatic run_instr(input ins_t in, input logic clr, input string tag);
    int t0;
    int lat;
    int etog;
    accept(in, tag);
    t0 = tog_cnt;
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
    err_clr = clr;
    @(negedge clk);
    err_clr = 1'b0;
    chk({tag, " done_width"}, 32'(done), 32'd0);
    model_apply(in, clr, etog);
    chk({tag, " toggles"}, 32'(tog_cnt - t0), 32'(etog));
    check_state(tag);
  endtask

  initial begin
    vec_t vecs [8];
    ins_t q [3];
    ins_t rin;
    logic [4:0] rop;
    int d0;
    int t0;
    int n_acc;
    int etog;
    int sum_tog;

    vecs[0] = '{mk(OP_MOVI, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5), 3'd1, 16'd5, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{mk(OP_MOVI, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3), 3'd2, 16'd3, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{mk(OP_ADD,  3'd3, 3'd1, 3'd2, 1'b0, 16'd0), 3'd3, 16'd8, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{mk(OP_MOVI, 3'd2, 3'd0, 3'd0, 1'b1, 16'd5), 3'd2, 16'd5, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{mk(OP_CMP,  3'd7, 3'd1, 3'd2, 1'b0, 16'd0), 3'd7, 16'd0, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{mk(OP_MOV,  3'd4, 3'd1, 3'd0, 1'b0, 16'd0), 3'd4, 16'd5, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{mk(OP_DIV,  3'd5, 3'd1, 3'd0, 1'b0, 16'd0), 3'd5, 16'd0, 4'b1000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{mk(5'h1F,   3'd6, 3'd1, 3'd2, 1'b0, 16'd0), 3'd1, 16'd5, 4'b1000, 1'b0, 1'b1, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset instr_ready", 32'(instr_ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset alu_enable", 32'(alu_enable), 32'd0);
    chk("reset alu_operation", 32'(alu_operation), 32'd0);
    chk("reset alu_in1", 32'(alu_in1), 32'd0);
    chk("reset alu_in2", 32'(alu_in2), 32'd0);
    check_state("reset");
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run_instr(vecs[k].in, 1'b0, $sformatf("vec%0d", k));
      dbg_addr = vecs[k].chk_reg;
      #1;
      chk($sformatf("vec%0d table_reg", k), dbg_data, vecs[k].chk_val);
      chk($sformatf("vec%0d table_flags", k), flags_q, vecs[k].chk_flags);
      chk($sformatf("vec%0d table_flag_z", k), 32'(flags_q[FLAG_Z]), 32'(vecs[k].chk_flags[3]));
      chk($sformatf("vec%0d table_div", k), div_zero_err, vecs[k].chk_div);
      chk($sformatf("vec%0d table_ill", k), illegal_op_err, vecs[k].chk_ill);
      if (vecs[k].clr_after) begin
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_div = 1'b0;
        m_ill = 1'b0;
        chk($sformatf("vec%0d err_clr div", k), div_zero_err, 1'b0);
      end
    end

    // Clear and a fresh error in the same cycle: the error survives, the other bit clears.
    run_instr(mk(OP_DIV, 3'd5, 3'd1, 3'd0, 1'b1, 16'd0), 1'b0, "div_imm0");
    run_instr(mk(5'h00, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0), 1'b1, "clr_vs_err");
    chk("clr_vs_err div", div_zero_err, 1'b0);
    chk("clr_vs_err ill", illegal_op_err, 1'b1);

    // Reset during SAMPLE of ADD r6 aborts it.
    d0 = done_cnt;
    accept(mk(OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 16'd0), "rst_mid");
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_mid done", 32'(done), 32'd0);
    chk("rst_mid alu_enable", 32'(alu_enable), 32'd0);
    model_reset();
    check_state("rst_mid");
    repeat (6) @(negedge clk);
    #1;
    chk("rst_mid no_done", 32'(done_cnt - d0), 32'd0);

    // Back-to-back with valid held high; busy-time offers must be ignored.
    q[0] = mk(OP_MOVI, 3'd2, 3'd0, 3'd0, 1'b1, 16'h1234);
    q[1] = mk(OP_MOVI, 3'd1, 3'd0, 3'd0, 1'b1, 16'h8000);
    q[2] = mk(OP_ADD,  3'd1, 3'd1, 3'd1, 1'b0, 16'd0);
    d0 = done_cnt;
    t0 = tog_cnt;
    n_acc = 0;
    for (int c = 0; c < 60 && n_acc < 3; c++) begin
      @(negedge clk);
      drive(q[n_acc]);
      instr_valid = 1'b1;
      if (instr_ready === 1'b1) n_acc++;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b accepts", 32'(n_acc), 32'd3);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (done_cnt - d0 >= 3) break;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("b2b done_pulses", 32'(done_cnt - d0), 32'd3);
    sum_tog = 0;
    for (int k = 0; k < 3; k++) begin
      model_apply(q[k], 1'b0, etog);
      sum_tog += etog;
    end
    chk("b2b toggles", 32'(tog_cnt - t0), 32'(sum_tog));
    check_state("b2b");
    chk("b2b flags_zcv", flags_q, 4'b1011);
    dbg_addr = 3'd1;
    #1;
    chk("b2b r1", dbg_data, 16'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 8) rop = 5'($urandom_range(1, 23));
      else if ($urandom_range(0, 1) == 1) rop = 5'($urandom_range(24, 31));
      else rop = 5'd0;
      rin = mk(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
      run_instr(rin, 1'($urandom_range(0, 5) == 0), $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
